// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit clock display scanner:
// segment patterns, scan position codes and the scan FSM states.
package display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_COLON = 7'h7C;

    // Scan positions; the encoding is the HC138 select code
    typedef enum logic [2:0] {
        POS_HT  = 3'd0,
        POS_HO  = 3'd1,
        POS_COL = 3'd2,
        POS_MT  = 3'd3,
        POS_MO  = 3'd4
    } pos_e;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Frame-wide copy of the inputs so a frame never mixes two times
    typedef struct packed {
        logic [3:0] ht;
        logic [3:0] ho;
        logic [3:0] mt;
        logic [3:0] mo;
        logic       colon;
    } snap_t;

    // Fixed scan order, last position wraps back to the first
    function automatic pos_e next_pos(input pos_e p);
        case (p)
            POS_HT:  next_pos = POS_HO;
            POS_HO:  next_pos = POS_COL;
            POS_COL: next_pos = POS_MT;
            POS_MT:  next_pos = POS_MO;
            default: next_pos = POS_HT;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, {g,f,e,d,c,b,a}, 0 = segment lit
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed scanner for an HH:MM LED display. Each of the five positions
// gets one blank cycle (select already moved, segments dark) then DWELL
// drive cycles. Inputs are captured once per frame at the start of
// position 0. Optional feature: define DISPLAY_LZB_EN to blank a leading
// zero in the hours-tens digit.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic [3:0] hrs_tens,
    input  logic [3:0] hrs_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic       colon_on,
    output logic [6:0] segment_data,
    output logic [2:0] digit_select,
    output logic       frame_done
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    scan_state_e state_q, state_d;
    pos_e        pos_q, pos_d;
    logic [3:0]  dwell_q, dwell_d;
    snap_t       snap_q, snap_d;
    snap_t       live;
    logic        first_q;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  sel_q, sel_d;
    logic        fd_q, fd_d;
    logic [3:0]  digit;
    logic [6:0]  digit_seg;
    logic        lzb;

    assign live = {hrs_tens, hrs_ones, min_tens, min_ones, colon_on};

    // Scan sequencing: blank/drive per position, snapshot on entering position 0
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dwell_d = dwell_q;
        snap_d  = snap_q;
        if (first_q) begin
            // First edge out of reset starts a fresh frame
            state_d = BLANK;
            pos_d   = POS_HT;
            dwell_d = 4'd0;
            snap_d  = live;
        end else if (state_q == BLANK) begin
            state_d = DRIVE;
        end else if (dwell_q == DWELL_LAST) begin
            state_d = BLANK;
            pos_d   = next_pos(pos_q);
            dwell_d = 4'd0;
            if (pos_q == POS_MO) begin
                snap_d = live;
            end
        end else begin
            dwell_d = dwell_q + 4'd1;
        end
    end

    // Pick the snapshot digit for the upcoming position
    always_comb begin
        digit = snap_d.ht;
        case (pos_d)
            POS_HO:  digit = snap_d.ho;
            POS_MT:  digit = snap_d.mt;
            POS_MO:  digit = snap_d.mo;
            default: digit = snap_d.ht;
        endcase
    end

    seg7_decode u_decode (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

`ifdef DISPLAY_LZB_EN
    assign lzb = (pos_d == POS_HT) && (snap_d.ht == 4'd0);
`else
    assign lzb = 1'b0;
`endif

    // Output values for the cycle being entered, so the registers line up with state
    always_comb begin
        seg_d = digit_seg;
        if (state_d == BLANK) begin
            seg_d = SEG_BLANK;
        end else if (pos_d == POS_COL) begin
            seg_d = snap_d.colon ? SEG_COLON : SEG_BLANK;
        end else if (lzb) begin
            seg_d = SEG_BLANK;
        end
        sel_d = pos_d;
        fd_d  = (state_d == DRIVE) && (pos_d == POS_MO) && (dwell_d == DWELL_LAST);
    end

    // State and registered outputs; reset blanks the display immediately
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            pos_q   <= POS_HT;
            dwell_q <= 4'd0;
            snap_q  <= '0;
            first_q <= 1'b1;
            seg_q   <= SEG_BLANK;
            sel_q   <= 3'd0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dwell_q <= dwell_d;
            snap_q  <= snap_d;
            first_q <= 1'b0;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
        end
    end

    assign segment_data = seg_q;
    assign digit_select = sel_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    logic       clk_1ms = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones;
    logic       colon_on;
    logic [6:0] seg4, seg1;
    logic [2:0] sel4, sel1;
    logic       fd4, fd1;

    int n_checks = 0;
    int n_errors = 0;
    int g = 0;

`ifdef DISPLAY_LZB_EN
    localparam logic [6:0] LZ0 = 7'h7F;
`else
    localparam logic [6:0] LZ0 = 7'h40;
`endif

    display_scan #(.DWELL(4)) dut4 (
        .clk_1ms(clk_1ms), .reset(reset),
        .hrs_tens(hrs_tens), .hrs_ones(hrs_ones),
        .min_tens(min_tens), .min_ones(min_ones), .colon_on(colon_on),
        .segment_data(seg4), .digit_select(sel4), .frame_done(fd4)
    );

    display_scan #(.DWELL(1)) dut1 (
        .clk_1ms(clk_1ms), .reset(reset),
        .hrs_tens(hrs_tens), .hrs_ones(hrs_ones),
        .min_tens(min_tens), .min_ones(min_ones), .colon_on(colon_on),
        .segment_data(seg1), .digit_select(sel1), .frame_done(fd1)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1ms);
        #2;
    endtask

    // Hand-decoded drive patterns per frame, positions 0..4
    function automatic logic [6:0] frame_seg(input int f, input int p);
        logic [34:0] row;
        case (f)
            0:       row = {7'h79, 7'h24, 7'h7C, 7'h30, 7'h19}; // 1 2 : 3 4
            1:       row = {7'h79, 7'h24, 7'h7C, 7'h30, 7'h10}; // 1 2 : 3 9
            2:       row = {7'h3F, 7'h24, 7'h7F, 7'h30, 7'h10}; // - 2   3 9
            3:       row = {LZ0,   7'h24, 7'h7F, 7'h30, 7'h10}; // 0 2   3 9
            default: row = {7'h12, 7'h02, 7'h7C, 7'h78, 7'h00}; // 5 6 : 7 8
        endcase
        return row[(4 - p) * 7 +: 7];
    endfunction

    initial begin
        hrs_tens = 4'd1; hrs_ones = 4'd2; min_tens = 4'd3; min_ones = 4'd4;
        colon_on = 1'b1;
        #12;
        check("rst seg", seg4, 7'h7F);
        check("rst sel", sel4, 3'd0);
        check("rst fd", fd4, 1'b0);
        check("rst seg d1", seg1, 7'h7F);
        reset = 1'b0;

        for (int f = 0; f < 5; f++) begin
            for (int c = 1; c <= 25; c++) begin
                int pos, ph, p1;
                step();
                g++;
                pos = (c - 1) / 5;
                ph  = (c - 1) % 5;
                check($sformatf("sel f%0d c%0d", f, c), sel4, pos);
                check($sformatf("seg f%0d c%0d", f, c), seg4, (ph == 0) ? 7'h7F : frame_seg(f, pos));
                check($sformatf("fd f%0d c%0d", f, c), fd4, (c == 25));
                p1 = ((g - 1) % 10) / 2;
                check($sformatf("d1 sel g%0d", g), sel1, p1);
                check($sformatf("d1 fd g%0d", g), fd1, (g % 10 == 0));
                if ((g - 1) % 2 == 0)
                    check($sformatf("d1 blank g%0d", g), seg1, 7'h7F);
                else if (g <= 10)
                    check($sformatf("d1 seg g%0d", g), seg1, frame_seg(0, p1));
                if (c == 10) begin
                    case (f)
                        0: min_ones = 4'd9;
                        1: begin hrs_tens = 4'hC; colon_on = 1'b0; end
                        2: hrs_tens = 4'd0;
                        3: begin hrs_tens = 4'd5; hrs_ones = 4'd6; min_tens = 4'd7;
                                 min_ones = 4'd8; colon_on = 1'b1; end
                        default: ;
                    endcase
                end
            end
            $display("frame %0d scanned, checks so far %0d", f, n_checks);
        end

        // Walk into position 3 drive, then hit reset between edges
        for (int c = 1; c <= 18; c++) step();
        check("pre-rst sel", sel4, 3'd3);
        check("pre-rst seg", seg4, 7'h78);
        #1;
        reset = 1'b1;
        #1;
        check("async rst seg", seg4, 7'h7F);
        check("async rst sel", sel4, 3'd0);
        check("async rst fd", fd4, 1'b0);
        check("async rst sel d1", sel1, 3'd0);
        step();
        check("held rst seg", seg4, 7'h7F);
        reset = 1'b0;
        step();
        check("restart blank seg", seg4, 7'h7F);
        check("restart blank sel", sel4, 3'd0);
        step();
        check("restart drive seg", seg4, 7'h12);
        check("restart drive sel", sel4, 3'd0);
        check("restart fd", fd4, 1'b0);
        check("restart drive seg d1", seg1, 7'h12);
        $display("reset recovery done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
